// File: rtl/contour_fill.sv
// rtl/contour_fill.sv - rebuilds a solid object mask from a contour bitmap by border flood fill
module contour_fill #(
    parameter int W = 10,
    parameter int H = 10,
    localparam int N = W * H,
    localparam int CW = $clog2(W * H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  contour,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  filled,
    output logic [CW-1:0] steps,
    output logic          timeout
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    function automatic logic [N-1:0] col_mask(input int col);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < H; r++) m[r*W+col] = 1'b1;
        return m;
    endfunction

    function automatic logic [N-1:0] edge_mask();
        logic [N-1:0] m;
        m = col_mask(0) | col_mask(W-1);
        for (int c = 0; c < W; c++) begin
            m[c]           = 1'b1;
            m[(H-1)*W + c] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [N-1:0] COL_FIRST = col_mask(0);
    localparam logic [N-1:0] COL_LAST  = col_mask(W-1);
    localparam logic [N-1:0] BORDER    = edge_mask();
    localparam logic [CW-1:0] STEP_CAP_M1 = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  cont_q, cont_d;
    logic [N-1:0]  bg_q, bg_d;
    logic [N-1:0]  filled_q, filled_d;
    logic [CW-1:0] steps_q, steps_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [N-1:0]  dil, nb;

    // Horizontal shifts are masked so a row never bleeds into its neighbour row.
    always_comb begin
        dil = (bg_q >> W) | (bg_q << W)
            | ((bg_q >> 1) & ~COL_LAST)
            | ((bg_q << 1) & ~COL_FIRST);
        nb  = bg_q | (dil & ~cont_q);
    end

    always_comb begin
        state_d   = state_q;
        cont_d    = cont_q;
        bg_d      = bg_q;
        filled_d  = filled_q;
        steps_d   = steps_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cont_d    = contour;
                    bg_d      = BORDER & ~contour;
                    steps_d   = '0;
                    timeout_d = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = ITER;
                end
            end
            ITER: begin
                if (nb == bg_q) begin
                    filled_d = ~bg_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    bg_d    = nb;
                    steps_d = steps_q + 1'b1;
                    // Safety net: a flood can never need more steps than there are pixels.
                    if (steps_q == STEP_CAP_M1) begin
                        filled_d  = ~nb;
                        timeout_d = 1'b1;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cont_q    <= '0;
            bg_q      <= '0;
            filled_q  <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cont_q    <= cont_d;
            bg_q      <= bg_d;
            filled_q  <= filled_d;
            steps_q   <= steps_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign filled  = filled_q;
    assign steps   = steps_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_contour_fill.sv
// tb/tb_contour_fill.sv - scoreboard bench for contour_fill
module tb_contour_fill;
    localparam int W = 10;
    localparam int H = 10;
    localparam int N = W * H;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  contour;
    logic          busy, done, timeout;
    logic [N-1:0]  filled;
    logic [CW-1:0] steps;

    contour_fill #(.W(W), .H(H)) dut (
        .clk(clk), .rst(rst), .start(start), .contour(contour),
        .busy(busy), .done(done), .filled(filled), .steps(steps), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] filled;
        int           steps;
        logic         timeout;
        int           lat;
        int           c0;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic done_prev = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Rows given as a concatenation with row 0 in the MSBs and column 0 leftmost.
    function automatic logic [N-1:0] pk(input logic [N-1:0] v);
        logic [N-1:0] o;
        for (int i = 0; i < N; i++) o[i] = v[N-1-i];
        return o;
    endfunction

    always @(negedge clk) begin
        if (!rst && done && !done_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 128'(1), 128'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_filled"},  128'(filled),  128'(e.filled));
                check({e.name, "_steps"},   128'(steps),   128'(e.steps));
                check({e.name, "_timeout"}, 128'(timeout), 128'(e.timeout));
                check({e.name, "_latency"}, 128'(cycle - e.c0), 128'(e.lat));
            end
        end
        done_prev <= done;
    end

    task automatic push_exp(input string name, input logic [N-1:0] f, input int st, input int c0);
        exp_t e;
        e.name = name; e.filled = f; e.steps = st; e.timeout = 1'b0;
        e.lat = st + 1; e.c0 = c0;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) check({name, "_done_timeout"}, 128'(0), 128'(1));
        @(negedge clk);
    endtask

    task automatic run_fill(input string name, input logic [N-1:0] c,
                            input logic [N-1:0] f, input int st);
        @(negedge clk);
        contour = c;
        start   = 1'b1;
        push_exp(name, f, st, cycle + 1);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_start"}, 128'({busy, done}), 128'(2'b10));
        wait_done(name);
    endtask

    logic [N-1:0] shape_c, shape_f, full_c, diam_c, diam_f;

    initial begin
        shape_c = pk({10'b0000000000, 10'b0111001110, 10'b0101001010, 10'b0101001010,
                      10'b0100110010, 10'b0100110010, 10'b0101001010, 10'b0101001010,
                      10'b0111001110, 10'b0000000000});
        shape_f = pk({10'b0000000000, 10'b0111001110, 10'b0111001110, 10'b0111001110,
                      10'b0111111110, 10'b0111111110, 10'b0111001110, 10'b0111001110,
                      10'b0111001110, 10'b0000000000});
        diam_c  = pk({10'b0000000000, 10'b0000000000, 10'b0000100000, 10'b0001010000,
                      10'b0010001000, 10'b0001010000, 10'b0000100000, 10'b0000000000,
                      10'b0000000000, 10'b0000000000});
        diam_f  = pk({10'b0000000000, 10'b0000000000, 10'b0000100000, 10'b0001110000,
                      10'b0011111000, 10'b0001110000, 10'b0000100000, 10'b0000000000,
                      10'b0000000000, 10'b0000000000});
        full_c  = '1;

        rst = 1'b1; start = 1'b0; contour = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",    128'(busy),    128'(0));
        check("reset_done",    128'(done),    128'(0));
        check("reset_filled",  128'(filled),  128'(0));
        check("reset_steps",   128'(steps),   128'(0));
        check("reset_timeout", 128'(timeout), 128'(0));

        run_fill("shape", shape_c, shape_f, 3);
        run_fill("empty", '0, '0, 4);
        run_fill("full", full_c, full_c, 0);
        run_fill("diagonal", diam_c, diam_f, 3);

        // Start from DONE, then a second start plus a changed contour mid-fill.
        @(negedge clk);
        contour = shape_c;
        start   = 1'b1;
        push_exp("ignored_start", shape_f, 3, cycle + 1);
        @(negedge clk);
        start = 1'b0;
        check("restart_done_cleared", 128'({busy, done}), 128'(2'b10));
        contour = full_c;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        contour = '0;
        wait_done("ignored_start");

        run_fill("rerun_empty", '0, '0, 4);

        // Reset on the second ITER edge aborts the fill.
        @(negedge clk);
        contour = shape_c;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   128'(busy),   128'(0));
        check("abort_done",   128'(done),   128'(0));
        check("abort_filled", 128'(filled), 128'(0));
        check("abort_steps",  128'(steps),  128'(0));

        run_fill("after_abort", shape_c, shape_f, 3);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/contour_fill.md
Name: contour_fill

Overview:
- Inverse of the contour-extraction stage. It takes a flattened binary contour bitmap and rebuilds the solid object mask.
- The mask is built by iterative 4-connected background flood from the image border; every pixel the flood cannot reach is object.
- Sequential and multi-cycle: one flood step per clock, with a start/busy/done handshake.
- Sits after the contour stage, so a round trip (image -> contour -> contour_fill) reproduces the original solid image.

Parameters:
- W, 10, image width in pixels.
- H, 10, image height in pixels.
- CW, derived = clog2(W*H+1) (7 for defaults), width of the step counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to fill; sampled only while idle.
- contour  input  W*H  contour bitmap. Pixel (r,c) is bit r*W+c, r=0 is the top row, at bits [W-1:0].
- busy  output  1  high while a fill is in progress.
- done  output  1  high from completion until the next accepted start or rst.
- filled  output  W*H  filled object mask, same bit mapping as contour; valid while done=1.
- steps  output  CW  number of flood iterations that changed the background set.
- timeout  output  1  set with done if the iteration cap is hit before convergence.

Behaviour:
- States are IDLE, ITER and DONE. rst at any edge forces IDLE, aborting any fill in progress.
- Reset values are busy=0, done=0, filled=0, steps=0, timeout=0. Internal registers cont_r and bg are cleared.
- IDLE or DONE, start=1 at edge E0:
  - cont_r <= contour.
  - bg <= border_mask & ~contour, where border_mask is rows 0 and H-1 plus columns 0 and W-1.
  - steps <= 0, timeout <= 0, done <= 0, busy <= 1, state -> ITER.
- start while in ITER is ignored. The contour input is not re-sampled during a fill.
- ITER, each edge:
  - Compute nb = bg | (dil4(bg) & ~cont_r).
  - dil4 is the OR of bg shifted one pixel up, down, left and right, with zero fill at image edges. No wrap between rows: the left/right shifts mask column 0 and column W-1.
  - If nb != bg: bg <= nb, steps <= steps+1.
  - If nb == bg: filled <= ~bg, done <= 1, busy <= 0, state -> DONE.
  - If steps reaches W*H while nb != bg: filled <= ~nb, timeout <= 1, done <= 1, busy <= 0, state -> DONE. This is unreachable for legal inputs but is mandatory as a safety net.
- Latency: with n changing iterations, done is visible after edge E(n+1), i.e. n+1 clocks after the start-sampling edge.
- Contour pixels are never background, so every contour pixel is 1 in filled.
- Connectivity is strictly 4-neighbour. Diagonal gaps in the contour do not leak.
- DONE: filled, steps and done are held stable until the next accepted start or rst.
- start=1 in DONE begins a new fill at that edge. done drops on that same edge.
- All logic is bit-parallel. No memories; every flood step is one combinational update of all W*H bits.

Test Plan:
- Reset release check:
  - Stimulus: assert rst for 2 cycles, then release.
  - Required: busy=0, done=0, filled=0, steps=0, timeout=0.
- Round-trip shape:
  - Stimulus: contour rows top to bottom are 0000000000, 0111001110, 0101001010, 0101001010, 0100110010, 0100110010, 0101001010, 0101001010, 0111001110, 0000000000. Pulse start.
  - Required: done 4 clocks after the start edge, steps=3, timeout=0.
  - Required filled rows: 0000000000, then 0111001110 three times, 0111111110 twice, 0111001110 three times, 0000000000.
- Empty contour:
  - Stimulus: contour=0.
  - Required: steps=4, done after 5 clocks, filled=0.
- Full contour:
  - Stimulus: contour all ones.
  - Required: steps=0, done 1 clock after start, filled all ones.
- Restart and ignored start:
  - Stimulus: pulse start again mid-ITER with a different contour.
  - Required: ignored; the result matches the first contour. A start in DONE re-runs and clears done for the duration of the new fill.
- Reset mid-fill:
  - Stimulus: assert rst on the 2nd ITER cycle.
  - Required: next cycle busy=0, done=0, filled=0. A subsequent start gives the correct result.
